// File: rtl/pc_fetch_control.sv
// pc_fetch_control: fetch-stage PC register, imem read request and branch redirect / flush control.
// Ports: CLK, RESETN (async, active-low); BRANCH_TAKEN, BRANCH_TARGET from EX; STALL from the hazard unit;
// IMEM_BUSYWAIT from imem; IMEM_READ, PC, PC_PLUS4, FETCH_VALID, FLUSH to imem and the IF/ID, ID/EX registers.
module pc_fetch_control #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    input  logic        STALL,
    input  logic        IMEM_BUSYWAIT,
    output logic        IMEM_READ,
    output logic [31:0] PC,
    output logic [31:0] PC_PLUS4,
    output logic        FETCH_VALID,
    output logic        FLUSH
);

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        DISCARD
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] redirect_pc_q;
    logic [31:0] redirect_pc_d;
    logic [31:0] target;
    logic        unused_target_lsbs;

    // Targets are word-aligned by dropping the low bits; no trap is raised here.
    assign target             = {BRANCH_TARGET[31:2], 2'b00};
    assign unused_target_lsbs = ^BRANCH_TARGET[1:0];

    assign PC          = pc_q;
    assign PC_PLUS4    = pc_q + 32'd4;
    assign IMEM_READ   = (state_q != BOOT);
    assign FLUSH       = BRANCH_TAKEN & (state_q != BOOT);
    assign FETCH_VALID = (state_q == FETCH) & ~IMEM_BUSYWAIT & ~BRANCH_TAKEN;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            redirect_pc_q <= 32'h0000_0000;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        redirect_pc_d = redirect_pc_q;
        case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (BRANCH_TAKEN) begin
                    // With a read in flight the address must stay put, so the
                    // target is parked and the returning word is dropped later.
                    if (IMEM_BUSYWAIT) begin
                        redirect_pc_d = target;
                        state_d       = DISCARD;
                    end else begin
                        pc_d = target;
                    end
                end else if (!STALL && !IMEM_BUSYWAIT) begin
                    pc_d = PC_PLUS4;
                end
            end
            DISCARD: begin
                if (BRANCH_TAKEN) begin
                    // A newer redirect overrides the parked one.
                    redirect_pc_d = target;
                    if (!IMEM_BUSYWAIT) begin
                        pc_d    = target;
                        state_d = FETCH;
                    end
                end else if (!IMEM_BUSYWAIT) begin
                    pc_d    = redirect_pc_q;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = BOOT;
                pc_d    = RESET_PC;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_fetch_control.sv
// tb_pc_fetch_control: table-driven bench for pc_fetch_control with an expected-value queue.
// Rows give one cycle of inputs and the outputs expected during that cycle.
module tb_pc_fetch_control;

    logic        CLK;
    logic        RESETN;
    logic        BRANCH_TAKEN;
    logic [31:0] BRANCH_TARGET;
    logic        STALL;
    logic        IMEM_BUSYWAIT;
    logic        IMEM_READ;
    logic [31:0] PC;
    logic [31:0] PC_PLUS4;
    logic        FETCH_VALID;
    logic        FLUSH;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        rst_n;
        logic        bt;
        logic [31:0] tgt;
        logic        stall;
        logic        busy;
        logic [31:0] pc;
        logic        rd;
        logic        vl;
        logic        fl;
    } vec_t;

    typedef struct {
        int          row;
        logic [31:0] pc;
        logic [31:0] plus4;
        logic        rd;
        logic        vl;
        logic        fl;
    } exp_t;

    vec_t vec_a[$];
    vec_t vec_b[$];
    exp_t sb[$];

    pc_fetch_control #(
        .RESET_PC(32'h0000_0000)
    ) dut (
        .CLK          (CLK),
        .RESETN       (RESETN),
        .BRANCH_TAKEN (BRANCH_TAKEN),
        .BRANCH_TARGET(BRANCH_TARGET),
        .STALL        (STALL),
        .IMEM_BUSYWAIT(IMEM_BUSYWAIT),
        .IMEM_READ    (IMEM_READ),
        .PC           (PC),
        .PC_PLUS4     (PC_PLUS4),
        .FETCH_VALID  (FETCH_VALID),
        .FLUSH        (FLUSH)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    function automatic vec_t v(
        input logic rst_n, input logic bt, input logic [31:0] tgt,
        input logic stall, input logic busy,
        input logic [31:0] pc, input logic rd, input logic vl, input logic fl
    );
        vec_t r;
        r.rst_n = rst_n;
        r.bt    = bt;
        r.tgt   = tgt;
        r.stall = stall;
        r.busy  = busy;
        r.pc    = pc;
        r.rd    = rd;
        r.vl    = vl;
        r.fl    = fl;
        return r;
    endfunction

    task automatic chk(input string nm, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s row %0d: got %h want %h", nm, row, act, exp);
        end
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard: queue empty, got 0 want 1 entry");
        end else begin
            e = sb.pop_front();
            chk("pc", e.row, PC, e.pc);
            chk("pc_plus4", e.row, PC_PLUS4, e.plus4);
            chk("imem_read", e.row, {31'd0, IMEM_READ}, {31'd0, e.rd});
            chk("fetch_valid", e.row, {31'd0, FETCH_VALID}, {31'd0, e.vl});
            chk("flush", e.row, {31'd0, FLUSH}, {31'd0, e.fl});
        end
    endtask

    task automatic apply(input vec_t x, input int row);
        exp_t e;
        RESETN        = x.rst_n;
        BRANCH_TAKEN  = x.bt;
        BRANCH_TARGET = x.tgt;
        STALL         = x.stall;
        IMEM_BUSYWAIT = x.busy;
        e.row   = row;
        e.pc    = x.pc;
        e.plus4 = x.pc + 32'd4;
        e.rd    = x.rd;
        e.vl    = x.vl;
        e.fl    = x.fl;
        sb.push_back(e);
        #2;
        pop_check();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // rst_n bt tgt stall busy | pc rd vl fl
        vec_a.push_back(v(0, 0, 32'h0,   0, 0, 32'h0, 0, 0, 0));
        vec_a.push_back(v(0, 1, 32'h55,  0, 0, 32'h0, 0, 0, 0));
        vec_a.push_back(v(1, 0, 32'h0,   0, 0, 32'h0, 0, 0, 0));
        vec_a.push_back(v(1, 0, 32'h0,   0, 0, 32'h0, 1, 1, 0));
        vec_a.push_back(v(1, 0, 32'h0,   0, 0, 32'h4, 1, 1, 0));
        vec_a.push_back(v(1, 0, 32'h0,   0, 0, 32'h8, 1, 1, 0));
        vec_a.push_back(v(1, 0, 32'h0,   0, 0, 32'hC, 1, 1, 0));
        vec_a.push_back(v(1, 0, 32'h0,   1, 0, 32'h10, 1, 1, 0));
        vec_a.push_back(v(1, 0, 32'h0,   1, 0, 32'h10, 1, 1, 0));
        vec_a.push_back(v(1, 1, 32'h80,  1, 0, 32'h10, 1, 0, 1));
        vec_a.push_back(v(1, 0, 32'h0,   0, 0, 32'h80, 1, 1, 0));
        vec_a.push_back(v(1, 1, 32'h22,  0, 0, 32'h84, 1, 0, 1));
        vec_a.push_back(v(1, 1, 32'h103, 0, 0, 32'h20, 1, 0, 1));
        vec_a.push_back(v(1, 0, 32'h0,   0, 0, 32'h100, 1, 1, 0));
        vec_a.push_back(v(1, 0, 32'h0,   0, 0, 32'h104, 1, 1, 0));
        vec_a.push_back(v(1, 1, 32'h40,  0, 0, 32'h108, 1, 0, 1));
        vec_a.push_back(v(1, 1, 32'h200, 0, 1, 32'h40, 1, 0, 1));
        vec_a.push_back(v(1, 0, 32'h0,   0, 1, 32'h40, 1, 0, 0));
        vec_a.push_back(v(1, 0, 32'h0,   0, 1, 32'h40, 1, 0, 0));
        vec_a.push_back(v(1, 0, 32'h0,   0, 0, 32'h40, 1, 0, 0));
        vec_a.push_back(v(1, 0, 32'h0,   0, 0, 32'h200, 1, 1, 0));
        vec_a.push_back(v(1, 1, 32'h250, 0, 1, 32'h204, 1, 0, 1));
        vec_a.push_back(v(1, 1, 32'h300, 0, 1, 32'h204, 1, 0, 1));
        vec_a.push_back(v(1, 0, 32'h0,   0, 0, 32'h204, 1, 0, 0));
        vec_a.push_back(v(1, 0, 32'h0,   0, 0, 32'h300, 1, 1, 0));
        vec_a.push_back(v(1, 1, 32'h400, 0, 1, 32'h304, 1, 0, 1));
        vec_a.push_back(v(1, 1, 32'h504, 0, 0, 32'h304, 1, 0, 1));
        vec_a.push_back(v(1, 0, 32'h0,   0, 0, 32'h504, 1, 1, 0));
        vec_a.push_back(v(1, 0, 32'h0,   0, 1, 32'h508, 1, 0, 0));
        vec_a.push_back(v(1, 0, 32'h0,   0, 0, 32'h508, 1, 1, 0));
        vec_a.push_back(v(1, 1, 32'hFFFF_FFFF, 0, 0, 32'h50C, 1, 0, 1));
        vec_a.push_back(v(1, 0, 32'h0,   0, 0, 32'hFFFF_FFFC, 1, 1, 0));
        vec_a.push_back(v(1, 0, 32'h0,   0, 0, 32'h0, 1, 1, 0));
        vec_a.push_back(v(1, 1, 32'h700, 0, 1, 32'h4, 1, 0, 1));
        vec_a.push_back(v(1, 0, 32'h0,   0, 1, 32'h4, 1, 0, 0));

        vec_b.push_back(v(0, 0, 32'h0,   0, 1, 32'h0, 0, 0, 0));
        vec_b.push_back(v(1, 1, 32'h700, 0, 0, 32'h0, 0, 0, 0));
        vec_b.push_back(v(1, 0, 32'h0,   0, 0, 32'h0, 1, 1, 0));
        vec_b.push_back(v(1, 0, 32'h0,   0, 0, 32'h4, 1, 1, 0));
        vec_b.push_back(v(1, 0, 32'h0,   0, 0, 32'h8, 1, 1, 0));

        RESETN        = 1'b0;
        BRANCH_TAKEN  = 1'b0;
        BRANCH_TARGET = 32'h0;
        STALL         = 1'b0;
        IMEM_BUSYWAIT = 1'b0;
        @(posedge CLK);
        #1;

        for (int i = 0; i < vec_a.size(); i++) apply(vec_a[i], i);

        // Mid-DISCARD asynchronous reset, asserted between clock edges.
        IMEM_BUSYWAIT = 1'b1;
        BRANCH_TAKEN  = 1'b0;
        #2;
        chk("pre_reset_pc", 100, PC, 32'h4);
        chk("pre_reset_read", 100, {31'd0, IMEM_READ}, 32'd1);
        RESETN = 1'b0;
        #1;
        chk("async_reset_pc", 101, PC, 32'h0);
        chk("async_reset_plus4", 101, PC_PLUS4, 32'h4);
        chk("async_reset_read", 101, {31'd0, IMEM_READ}, 32'd0);
        chk("async_reset_valid", 101, {31'd0, FETCH_VALID}, 32'd0);
        @(posedge CLK);
        #1;

        for (int i = 0; i < vec_b.size(); i++) apply(vec_b[i], 200 + i);

        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch_control.md
# pc_fetch_control

Fetch-stage program counter and redirect controller for the pipelined RV32 core. It consumes the branch-taken decision and target resolved in EX, and owns the PC register and the instruction-memory read request. It also generates the pipeline flush that kills wrong-path instructions. It is the receiving end of branch resolution: EX decides, this block redirects fetch, including redirects that arrive while an instruction-memory access is still in flight.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; low two bits must be 0

Ports:
- CLK  input  1  core clock; all state changes on rising edge
- RESETN  input  1  asynchronous, active-low reset
- BRANCH_TAKEN  input  1  from EX branch selection; 1 = redirect fetch this cycle (branches and JAL/JALR)
- BRANCH_TARGET  input  32  redirect address from EX; bits [1:0] ignored
- STALL  input  1  hazard unit; 1 = hold PC and do not advance fetch
- IMEM_BUSYWAIT  input  1  instruction memory; 1 = current read not complete
- IMEM_READ  output  1  instruction-memory read request
- PC  output  32  fetch address driven to instruction memory and the IF/ID register
- PC_PLUS4  output  32  PC + 4, modulo 2^32
- FETCH_VALID  output  1  1 = the instruction word on the memory bus is valid for IF/ID to latch at this edge
- FLUSH  output  1  1 = IF/ID and ID/EX load bubbles at this edge

## Operation
- State machine: BOOT, FETCH, DISCARD. Registered state: PC, state, REDIRECT_PC (32 bits).
- BOOT is the state on reset.
  - PC = RESET_PC; IMEM_READ = 0.
  - Moves to FETCH unconditionally at the first edge after RESETN deasserts.
  - BRANCH_TAKEN is ignored; FLUSH = 0.
- FETCH, with IMEM_READ = 1:
  - BRANCH_TAKEN = 1 and IMEM_BUSYWAIT = 0: PC <= {BRANCH_TARGET[31:2], 2'b00}; stay in FETCH.
  - BRANCH_TAKEN = 1 and IMEM_BUSYWAIT = 1: PC holds, so the in-flight address stays stable. REDIRECT_PC <= aligned target; go to DISCARD.
  - BRANCH_TAKEN = 0, STALL = 0, IMEM_BUSYWAIT = 0: PC <= PC + 4.
  - BRANCH_TAKEN = 0 and either STALL = 1 or IMEM_BUSYWAIT = 1: PC holds.
- DISCARD, with IMEM_READ = 1 and PC holding the old address:
  - The returning word is dropped.
  - IMEM_BUSYWAIT = 0 at the edge: PC <= REDIRECT_PC; go to FETCH.
  - BRANCH_TAKEN = 1 while in DISCARD: REDIRECT_PC <= the new aligned target (newest wins). If IMEM_BUSYWAIT is also 0 at that edge, PC <= the new target directly.
- BRANCH_TAKEN has priority over STALL. A stalled ID instruction is on the wrong path and is flushed.
- FLUSH = BRANCH_TAKEN & (state != BOOT).
- FETCH_VALID = (state == FETCH) & ~IMEM_BUSYWAIT & ~BRANCH_TAKEN.
- Arithmetic:
  - PC + 4 wraps: 32'hFFFF_FFFC advances to 32'h0000_0000.
  - Target bits [1:0] are forced to 0; no misalignment trap is raised in this block.

## Timing
- Reset (asynchronous, takes effect immediately, including mid-access or mid-DISCARD):
  - PC = RESET_PC, PC_PLUS4 = RESET_PC + 4, state = BOOT, REDIRECT_PC = 0.
  - IMEM_READ = 0, FLUSH = 0, FETCH_VALID = 0.
- Combinational outputs:
  - FLUSH and FETCH_VALID respond to BRANCH_TAKEN and IMEM_BUSYWAIT in the same cycle.
  - IMEM_READ and PC_PLUS4 follow state and PC.
- Redirect latency:
  - No access outstanding: target appears on PC one edge after BRANCH_TAKEN is sampled.
  - Access outstanding: target appears on PC at the edge where IMEM_BUSYWAIT is first sampled 0, at least 1 cycle later.
- The flush covers exactly the cycle BRANCH_TAKEN is high. The EX stage holds BRANCH_TAKEN for one cycle per resolved branch.
- Sequential fetch throughput: one PC advance per cycle while IMEM_BUSYWAIT = 0 and STALL = 0.
- PC never changes while IMEM_BUSYWAIT = 1, except on reset.

## Test plan
- Reset and boot:
  - Hold RESETN = 0, then release; run 4 cycles with BUSYWAIT = 0.
  - Required: PC = 0x0 (IMEM_READ = 0), then 0x0 (IMEM_READ = 1), then 0x4, 0x8. FETCH_VALID = 1 from the second cycle.
- Taken branch, memory ready:
  - In FETCH at PC = 0x20, BRANCH_TAKEN = 1, TARGET = 0x103.
  - Required: FLUSH = 1 and FETCH_VALID = 0 that cycle; next PC = 0x100; following PC = 0x104.
- Branch during a busy fetch:
  - PC = 0x40, BUSYWAIT = 1 for 3 cycles, BRANCH_TAKEN = 1 in the first of them with TARGET = 0x200.
  - Required: PC stays 0x40 with FETCH_VALID = 0 throughout. PC = 0x200 at the edge where BUSYWAIT is sampled 0.
  - Second branch to 0x300 during DISCARD: required PC lands on 0x300, not 0x200.
- Stall versus branch:
  - STALL = 1 for 2 cycles at PC = 0x10: required PC holds 0x10.
  - Then STALL = 1 with BRANCH_TAKEN = 1, TARGET = 0x80: required next PC = 0x80 and FLUSH = 1.
- Wrap and async reset:
  - Branch to 0xFFFF_FFFC, then advance: required PC = 0x0000_0000 and PC_PLUS4 = 0x4.
  - Assert RESETN = 0 mid-DISCARD, between clock edges: required PC = RESET_PC and IMEM_READ = 0 immediately. After release, boot resumes at RESET_PC with no stale redirect.
